// File: rtl/param_deserialiser_if.sv
// Byte-in / word-out handshake bundle for param_deserialiser.
// master drives bytes and word_ready; slave is the deserialiser.
interface param_deserialiser_if #(
    parameter int unsigned BYTES_PER_WORD = 4
);
    localparam int unsigned W  = 8 * BYTES_PER_WORD;
    localparam int unsigned CW = $clog2(BYTES_PER_WORD + 1);

    logic [7:0]    i_byte_data;
    logic          i_byte_valid;
    logic          i_flush;
    logic          i_word_ready;
    logic [W-1:0]  o_word_data;
    logic          o_word_valid;
    logic [CW-1:0] o_word_byte_count;
    logic          o_overflow;
    logic          o_timeout;

    modport master (
        output i_byte_data, i_byte_valid, i_flush, i_word_ready,
        input  o_word_data, o_word_valid, o_word_byte_count, o_overflow, o_timeout
    );

    modport slave (
        input  i_byte_data, i_byte_valid, i_flush, i_word_ready,
        output o_word_data, o_word_valid, o_word_byte_count, o_overflow, o_timeout
    );
endinterface

// File: rtl/param_deserialiser.sv
// Packs a UART byte stream into BYTES_PER_WORD-byte words with flush, idle
// timeout and a single output holding register.
module param_deserialiser #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned BYTE_ORDER     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                 i_clock,
    input logic                 i_reset,
    param_deserialiser_if.slave bus
);
    localparam int unsigned W       = 8 * BYTES_PER_WORD;
    localparam int unsigned CW      = $clog2(BYTES_PER_WORD + 1);
    localparam int unsigned TW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [0:0] {StFill, StPending} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  hold_data_q, hold_data_d;
    logic [CW-1:0] hold_count_q, hold_count_d;
    logic          hold_valid_q, hold_valid_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] idle_q, idle_d;

    logic          hold_free;
    logic          byte_accept;
    logic          complete;
    logic          timeout_fire;
    logic          emit;
    logic [W-1:0]  fill_data;
    logic [CW-1:0] fill_count;
    int unsigned   lane;

    // Shared datapath: accumulator contents as they would be after this cycle's byte.
    always_comb begin
        hold_free   = !hold_valid_q || bus.i_word_ready;
        byte_accept = bus.i_byte_valid && (state_q == StFill);
        lane        = (BYTE_ORDER == 0) ? (BYTES_PER_WORD - 1 - 32'(count_q)) : 32'(count_q);
        fill_data   = acc_q;
        for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
            if (byte_accept && (b == lane)) fill_data[8*b +: 8] = bus.i_byte_data;
        end
        fill_count   = count_q + CW'(byte_accept);
        complete     = byte_accept && (fill_count == CW'(BYTES_PER_WORD));
        // A byte in the same cycle resets the idle count, so it suppresses the timeout.
        timeout_fire = (TIMEOUT_CYCLES != 0) && (state_q == StFill) && (count_q != '0) &&
                       !bus.i_byte_valid && (idle_q == TW'(TO_LAST));
        emit         = (state_q == StFill) &&
                       (complete || ((bus.i_flush || timeout_fire) && (fill_count != '0)));
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= StFill;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:    if (emit && !hold_free) state_d = StPending;
            StPending: if (hold_free)          state_d = StFill;
            default:   state_d = StFill;
        endcase
    end

    always_comb begin
        acc_d        = acc_q;
        count_d      = count_q;
        hold_data_d  = hold_data_q;
        hold_count_d = hold_count_q;
        hold_valid_d = hold_valid_q && !bus.i_word_ready;
        overflow_d   = overflow_q;
        timeout_d    = timeout_fire;
        idle_d       = '0;
        unique case (state_q)
            StFill: begin
                if (emit && hold_free) begin
                    hold_data_d  = fill_data;
                    hold_count_d = fill_count;
                    hold_valid_d = 1'b1;
                    acc_d        = '0;
                    count_d      = '0;
                end else begin
                    acc_d   = fill_data;
                    count_d = fill_count;
                    if (!emit && (TIMEOUT_CYCLES != 0) && (count_q != '0) && !bus.i_byte_valid)
                        idle_d = idle_q + TW'(1);
                end
            end
            StPending: begin
                overflow_d = overflow_q | bus.i_byte_valid;
                if (hold_free) begin
                    hold_data_d  = acc_q;
                    hold_count_d = count_q;
                    hold_valid_d = 1'b1;
                    acc_d        = '0;
                    count_d      = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q        <= '0;
            count_q      <= '0;
            hold_data_q  <= '0;
            hold_count_q <= '0;
            hold_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            idle_q       <= '0;
        end else begin
            acc_q        <= acc_d;
            count_q      <= count_d;
            hold_data_q  <= hold_data_d;
            hold_count_q <= hold_count_d;
            hold_valid_q <= hold_valid_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            idle_q       <= idle_d;
        end
    end

    assign bus.o_word_data       = hold_data_q;
    assign bus.o_word_valid      = hold_valid_q;
    assign bus.o_word_byte_count = hold_count_q;
    assign bus.o_overflow        = overflow_q;
    assign bus.o_timeout         = timeout_q;
endmodule

// File: tb/tb_param_deserialiser.sv
// Directed bench: dut_a (MSB-first, 16-cycle timeout) and dut_b (LSB-first)
// share stimulus; expected values are hand-computed constants.
module tb_param_deserialiser;
    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #5 i_clock = ~i_clock;

    param_deserialiser_if #(.BYTES_PER_WORD(4)) bus_a ();
    param_deserialiser_if #(.BYTES_PER_WORD(4)) bus_b ();

    assign bus_b.i_byte_data  = bus_a.i_byte_data;
    assign bus_b.i_byte_valid = bus_a.i_byte_valid;
    assign bus_b.i_flush      = bus_a.i_flush;
    assign bus_b.i_word_ready = bus_a.i_word_ready;

    param_deserialiser #(
        .BYTES_PER_WORD(4), .BYTE_ORDER(0), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus_a)
    );

    param_deserialiser #(
        .BYTES_PER_WORD(4), .BYTE_ORDER(1), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic fl);
        bus_a.i_byte_data  = b;
        bus_a.i_byte_valid = 1'b1;
        bus_a.i_flush      = fl;
        step();
        bus_a.i_byte_valid = 1'b0;
        bus_a.i_flush      = 1'b0;
    endtask

    initial begin
        bus_a.i_byte_data  = 8'h00;
        bus_a.i_byte_valid = 1'b0;
        bus_a.i_flush      = 1'b0;
        bus_a.i_word_ready = 1'b1;
        i_reset            = 1'b1;
        step();
        step();
        check_eq("reset_valid", 64'(bus_a.o_word_valid), 64'd0);
        check_eq("reset_data", 64'(bus_a.o_word_data), 64'd0);
        check_eq("reset_count", 64'(bus_a.o_word_byte_count), 64'd0);
        check_eq("reset_overflow", 64'(bus_a.o_overflow), 64'd0);
        check_eq("reset_timeout", 64'(bus_a.o_timeout), 64'd0);
        i_reset = 1'b0;

        // Full word, both byte orders
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check_eq("full_early_valid", 64'(bus_a.o_word_valid), 64'd0);
        send(8'h44, 1'b0);
        check_eq("full_valid", 64'(bus_a.o_word_valid), 64'd1);
        check_eq("full_data_msb", 64'(bus_a.o_word_data), 64'h11223344);
        check_eq("full_count", 64'(bus_a.o_word_byte_count), 64'd4);
        check_eq("full_data_lsb", 64'(bus_b.o_word_data), 64'h44332211);
        check_eq("full_count_lsb", 64'(bus_b.o_word_byte_count), 64'd4);
        step();
        check_eq("full_valid_drop", 64'(bus_a.o_word_valid), 64'd0);
        check_eq("full_valid_drop_lsb", 64'(bus_b.o_word_valid), 64'd0);

        // Byte together with flush, then flush at count 0
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        check_eq("flush_valid", 64'(bus_a.o_word_valid), 64'd1);
        check_eq("flush_data", 64'(bus_a.o_word_data), 64'hAABBCC00);
        check_eq("flush_count", 64'(bus_a.o_word_byte_count), 64'd3);
        check_eq("flush_no_timeout", 64'(bus_a.o_timeout), 64'd0);
        step();
        check_eq("flush_valid_drop", 64'(bus_a.o_word_valid), 64'd0);
        bus_a.i_flush = 1'b1;
        step();
        bus_a.i_flush = 1'b0;
        check_eq("flush_empty_valid", 64'(bus_a.o_word_valid), 64'd0);
        step();
        check_eq("flush_empty_valid2", 64'(bus_a.o_word_valid), 64'd0);

        // Idle timeout after two bytes
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) begin
                check_eq("to_early_valid", 64'(bus_a.o_word_valid), 64'd0);
                check_eq("to_early_pulse", 64'(bus_a.o_timeout), 64'd0);
            end
        end
        check_eq("to_valid", 64'(bus_a.o_word_valid), 64'd1);
        check_eq("to_data", 64'(bus_a.o_word_data), 64'hAABB0000);
        check_eq("to_count", 64'(bus_a.o_word_byte_count), 64'd2);
        check_eq("to_pulse", 64'(bus_a.o_timeout), 64'd1);
        step();
        check_eq("to_pulse_end", 64'(bus_a.o_timeout), 64'd0);
        check_eq("to_valid_drop", 64'(bus_a.o_word_valid), 64'd0);

        // Backpressure: held word, pending word, dropped ninth byte
        bus_a.i_word_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
        check_eq("bp_overflow", 64'(bus_a.o_overflow), 64'd1);
        check_eq("bp_held_valid", 64'(bus_a.o_word_valid), 64'd1);
        check_eq("bp_held_data", 64'(bus_a.o_word_data), 64'h01020304);
        step();
        check_eq("bp_held_stable", 64'(bus_a.o_word_data), 64'h01020304);
        bus_a.i_word_ready = 1'b1;
        step();
        check_eq("bp_second_valid", 64'(bus_a.o_word_valid), 64'd1);
        check_eq("bp_second_data", 64'(bus_a.o_word_data), 64'h05060708);
        check_eq("bp_second_count", 64'(bus_a.o_word_byte_count), 64'd4);
        step();
        check_eq("bp_drained", 64'(bus_a.o_word_valid), 64'd0);
        check_eq("bp_overflow_sticky", 64'(bus_a.o_overflow), 64'd1);

        // Reset discards partial word; inputs during reset ignored
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        i_reset            = 1'b1;
        bus_a.i_byte_data  = 8'hFF;
        bus_a.i_byte_valid = 1'b1;
        step();
        i_reset            = 1'b0;
        bus_a.i_byte_valid = 1'b0;
        check_eq("rst_overflow", 64'(bus_a.o_overflow), 64'd0);
        check_eq("rst_valid", 64'(bus_a.o_word_valid), 64'd0);
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        check_eq("rst_no_stale_word", 64'(bus_a.o_word_valid), 64'd0);
        send(8'h0C, 1'b0);
        send(8'h0D, 1'b0);
        check_eq("rst_valid_word", 64'(bus_a.o_word_valid), 64'd1);
        check_eq("rst_data", 64'(bus_a.o_word_data), 64'h0A0B0C0D);
        check_eq("rst_overflow_after", 64'(bus_a.o_overflow), 64'd0);
        step();
        check_eq("rst_valid_drop", 64'(bus_a.o_word_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_deserialiser.md
PARAM_DESERIALISER -- requirements
Module: param_deserialiser

Interface
REQ-001 Parameter BYTES_PER_WORD, default 4, bytes per output word; legal range 2..8; W = 8*BYTES_PER_WORD.
REQ-002 Parameter BYTE_ORDER, default 0; 0 = first-received byte in most-significant byte, 1 = first-received byte in least-significant byte.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000; idle cycles before auto-flush of a partial word; 0 disables timeout.
REQ-004 i_clock  input  1  sole clock; all logic on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_byte_data  input  8  incoming byte from UART.
REQ-007 i_byte_valid  input  1  single-cycle strobe, i_byte_data valid this cycle.
REQ-008 i_flush  input  1  request to emit the current partial word.
REQ-009 o_word_data  output  W  assembled word for FIFO.
REQ-010 o_word_valid  output  1  o_word_data holds an unconsumed word.
REQ-011 i_word_ready  input  1  consumer accepts the word when o_word_valid and i_word_ready are both high.
REQ-012 o_word_byte_count  output  ceil(log2(BYTES_PER_WORD+1))  number of real bytes in o_word_data (BYTES_PER_WORD for a full word).
REQ-013 o_overflow  output  1  sticky, a byte was dropped.
REQ-014 o_timeout  output  1  one-cycle pulse, a timeout flush occurred.

Function
REQ-015 Block SHALL contain one accumulator (byte count 0..BYTES_PER_WORD) and one output holding register; states FILL (accumulating) and PENDING (accumulator complete, holding register occupied).
REQ-016 Arrival index k (0-based) SHALL place the byte at bits [8*(BYTES_PER_WORD-k)-1 : 8*(BYTES_PER_WORD-k-1)] when BYTE_ORDER=0, and at [8k+7 : 8k] when BYTE_ORDER=1; unfilled byte positions SHALL be zero.
REQ-017 Holding register is "free" when o_word_valid=0 or when o_word_valid and i_word_ready are both high in that cycle.
REQ-018 When the byte completing a word is accepted and the holding register is free, the word SHALL load into the holding register on that edge (o_word_valid high the next cycle; latency 1) and the accumulator SHALL clear to count 0.
REQ-019 If the holding register is not free, the completed word SHALL stay in the accumulator (PENDING) and transfer on the first cycle the register is free, then return to FILL.
REQ-020 An i_byte_valid in PENDING SHALL be dropped and set o_overflow; o_overflow clears only on reset.
REQ-021 o_word_valid SHALL stay high with o_word_data and o_word_byte_count stable until accepted; it drops the cycle after acceptance unless a new word loads on the same edge.
REQ-022 i_flush with count 1..BYTES_PER_WORD-1 in FILL SHALL transfer the zero-padded partial word with o_word_byte_count = count, subject to REQ-019 (the partial word becomes PENDING).
REQ-023 i_flush with count 0, or in PENDING, SHALL have no effect.
REQ-024 i_byte_valid and i_flush in the same cycle: the byte SHALL be included first, then flushed; if that byte completes the word, a normal full word is emitted, with no extra flush.
REQ-025 Idle counter SHALL count cycles in FILL with count>0 and no i_byte_valid, and SHALL clear on any accepted byte or transfer.
REQ-026 On reaching TIMEOUT_CYCLES, the block SHALL perform a flush per REQ-022 and pulse o_timeout for one cycle.
REQ-027 A timeout coinciding with i_byte_valid SHALL be suppressed, because the byte resets the idle counter.

Reset
REQ-028 On i_reset high at a clock edge: o_word_valid=0, o_word_data=0, o_word_byte_count=0, o_overflow=0, o_timeout=0, accumulator count=0, idle counter=0, state=FILL.
REQ-029 Reset SHALL discard any partial, pending or held word; inputs during reset SHALL be ignored.

Verification
REQ-030 Defaults, i_word_ready=1, bytes 11,22,33,44 -> cycle after 4th byte: o_word_data=0x11223344, count=4, o_word_valid high exactly 1 cycle.
REQ-031 BYTE_ORDER=1, same bytes -> o_word_data=0x44332211, count=4.
REQ-032 i_word_ready=0; 9 bytes 01..09 -> held word 0x01020304, pending 0x05060708, byte 09 dropped, o_overflow=1; raise ready -> words delivered in order, then o_word_valid=0.
REQ-033 TIMEOUT_CYCLES=16; bytes AA,BB then idle -> after 16 idle cycles: o_word_data=0xAABB0000, count=2, o_timeout single pulse.
REQ-034 Byte CC with i_flush in the same cycle after bytes AA,BB -> o_word_data=0xAABBCC00, count=3; i_flush at count 0 -> no output.
REQ-035 Bytes 01,02, then i_reset, then 0A,0B,0C,0D -> only word 0x0A0B0C0D emitted, o_overflow=0.
